// File: rtl/axis_spi_adc_multich.sv
// Multi-channel SPI ADC reader: shared cs_n/sclk, one miso per channel, and each
// captured frame is emitted as an NUM_CH-beat AXI-Stream packet.
module axis_spi_adc_multich #(
  parameter int DATA_W   = 16,
  parameter int NUM_CH   = 2,
  parameter int CLK_DIV  = 10,
  parameter int CONV_CYC = 30
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic [NUM_CH-1:0] miso,
  output logic              cs_n,
  output logic              sclk,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [3:0]        m_axis_tuser,
  output logic [15:0]       overrun_cnt,
  output logic [15:0]       frame_cnt
);

  localparam int CNT_MAX = (CONV_CYC > CLK_DIV) ? CONV_CYC : CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int HALF_N  = 2 * DATA_W;
  localparam int HALF_W  = $clog2(HALF_N + 1);

  localparam logic [CNT_W-1:0]  CONV_LAST = CNT_W'(CONV_CYC - 1);
  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_N - 1);
  localparam logic [3:0]        LAST_IDX  = 4'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SHIFT,
    LOAD
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HALF_W-1:0]  half_q, half_d;
  logic               sclk_q, sclk_d;
  logic               cs_n_q, cs_n_d;
  logic               sample_en;

  logic [DATA_W-1:0]  sr_q  [NUM_CH];
  logic [DATA_W-1:0]  buf_q [NUM_CH];
  logic               full_q;
  logic [3:0]         idx_q;
  logic [15:0]        ovr_q;
  logic [15:0]        frm_q;

  logic               beat_done;
  logic               last_done;
  logic               buf_free;
  logic               in_load;
  logic               load_ok;

  // cnt_q times CONV and each sclk half-period; half_q counts half-periods in SHIFT.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    sclk_d    = sclk_q;
    sample_en = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        half_d = '0;
        sclk_d = 1'b0;
        if (enable) state_d = CONV;
      end
      CONV: begin
        if (cnt_q == CONV_LAST) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d     = '0;
          sclk_d    = ~sclk_q;
          sample_en = ~sclk_q;
          if (half_q == HALF_LAST) begin
            half_d  = '0;
            state_d = LOAD;
          end else begin
            half_d = half_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        half_d  = '0;
        sclk_d  = 1'b0;
        state_d = enable ? CONV : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    cs_n_d = (state_d != SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) sr_q[i] <= '0;
    end else if (sample_en) begin
      for (int i = 0; i < NUM_CH; i++) sr_q[i] <= {sr_q[i][DATA_W-2:0], miso[i]};
    end
  end

  // A final-beat handshake frees the buffer in the same cycle, so a coincident LOAD is accepted.
  assign beat_done = full_q & m_axis_tready;
  assign last_done = beat_done & (idx_q == LAST_IDX);
  assign buf_free  = ~full_q | last_done;
  assign in_load   = (state_q == LOAD);
  assign load_ok   = in_load & buf_free;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < NUM_CH; k++) buf_q[k] <= '0;
      full_q <= 1'b0;
      idx_q  <= '0;
      ovr_q  <= '0;
      frm_q  <= '0;
    end else begin
      if (load_ok) begin
        for (int k = 0; k < NUM_CH; k++) buf_q[k] <= sr_q[k];
        full_q <= 1'b1;
        idx_q  <= '0;
        frm_q  <= frm_q + 1'b1;
      end else if (last_done) begin
        full_q <= 1'b0;
        idx_q  <= '0;
      end else if (beat_done) begin
        idx_q <= idx_q + 1'b1;
      end
      if (in_load && !buf_free && (ovr_q != 16'hFFFF)) begin
        ovr_q <= ovr_q + 1'b1;
      end
    end
  end

  always_comb begin
    m_axis_tdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx_q == 4'(k)) m_axis_tdata = buf_q[k];
    end
  end

  assign cs_n          = cs_n_q;
  assign sclk          = sclk_q;
  assign m_axis_tvalid = full_q;
  assign m_axis_tuser  = idx_q;
  assign m_axis_tlast  = full_q & (idx_q == LAST_IDX);
  assign overrun_cnt   = ovr_q;
  assign frame_cnt     = frm_q;

endmodule

// File: tb/tb_axis_spi_adc_multich.sv
// Directed bench for axis_spi_adc_multich with a behavioural MSB-first ADC per channel.
module tb_axis_spi_adc_multich;

  localparam int DATA_W   = 16;
  localparam int NUM_CH   = 2;
  localparam int CLK_DIV  = 2;
  localparam int CONV_CYC = 8;

  logic              clk;
  logic              resetn;
  logic              enable;
  logic [NUM_CH-1:0] miso;
  logic              cs_n;
  logic              sclk;
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [3:0]        tuser;
  logic [15:0]       overrunCnt;
  logic [15:0]       frameCnt;

  int nAsserts = 0;
  int nFail    = 0;
  int cyc      = 0;
  int fallCnt  = 0;

  logic [NUM_CH-1:0][DATA_W-1:0] adcWord;

  axis_spi_adc_multich #(
    .DATA_W  (DATA_W),
    .NUM_CH  (NUM_CH),
    .CLK_DIV (CLK_DIV),
    .CONV_CYC(CONV_CYC)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .miso         (miso),
    .cs_n         (cs_n),
    .sclk         (sclk),
    .m_axis_tdata (tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tlast (tlast),
    .m_axis_tuser (tuser),
    .overrun_cnt  (overrunCnt),
    .frame_cnt    (frameCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADC presents the MSB once cs_n falls and advances one bit per sclk falling edge.
  always @(posedge cs_n or negedge sclk) begin
    if (cs_n) fallCnt = 0;
    else      fallCnt = fallCnt + 1;
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      miso[k] = (fallCnt < DATA_W) ? adcWord[k][DATA_W-1-fallCnt] : 1'b0;
    end
  end

  task automatic applyStimulus(input logic en, input logic rdy);
    enable = en;
    tready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
      else begin
        nFail++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
      end
  endtask

  task automatic stepTo(input int n);
    while (cyc < n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  // Pulses reset for one edge; the cycle that follows is cycle 0 (IDLE).
  task automatic resetDut();
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc    = 0;
  endtask

  logic sclkAt [0:73];
  logic csAt   [0:73];
  int   firstLow, lastLow, lowCount, riseCnt, phaseErr, idleSclk, holdErr, quietErr;

  initial begin
    resetn  = 1'b0;
    adcWord = {16'h1234, 16'hA5C3};
    applyStimulus(1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cs_n", 32'(cs_n), 32'h1);
    checkOutput("rst_sclk", 32'(sclk), 32'h0);
    checkOutput("rst_tvalid", 32'(tvalid), 32'h0);
    checkOutput("rst_tlast", 32'(tlast), 32'h0);
    checkOutput("rst_tdata", 32'(tdata), 32'h0);
    checkOutput("rst_tuser", 32'(tuser), 32'h0);
    checkOutput("rst_overrun", 32'(overrunCnt), 32'h0);
    checkOutput("rst_frame", 32'(frameCnt), 32'h0);

    // First frame with tready high, recording the SPI waveform.
    $display("[TB] basic capture and SPI timing");
    resetn = 1'b1;
    applyStimulus(1'b1, 1'b1);
    cyc = 0;
    for (int c = 0; c <= 73; c++) begin
      stepTo(c);
      sclkAt[c] = sclk;
      csAt[c]   = cs_n;
    end
    firstLow = -1; lastLow = -1; lowCount = 0; riseCnt = 0; phaseErr = 0; idleSclk = 0;
    for (int c = 0; c <= 73; c++) begin
      if (!csAt[c]) begin
        if (firstLow < 0) firstLow = c;
        lastLow = c;
        lowCount++;
        if (sclkAt[c] !== 1'(((c - 9) / 2) % 2)) phaseErr++;
      end else if (sclkAt[c] !== 1'b0) begin
        idleSclk++;
      end
      if (c > 0 && sclkAt[c] && !sclkAt[c-1]) riseCnt++;
    end
    checkOutput("cs_first_low", 32'(firstLow), 32'd9);
    checkOutput("cs_last_low", 32'(lastLow), 32'd72);
    checkOutput("cs_low_count", 32'(lowCount), 32'd64);
    checkOutput("sclk_rises", 32'(riseCnt), 32'd16);
    checkOutput("sclk_phase_err", 32'(phaseErr), 32'd0);
    checkOutput("sclk_idle_err", 32'(idleSclk), 32'd0);
    checkOutput("load_tvalid", 32'(tvalid), 32'h0);

    stepTo(74);
    checkOutput("b0_tvalid", 32'(tvalid), 32'h1);
    checkOutput("b0_tdata", 32'(tdata), 32'hA5C3);
    checkOutput("b0_tuser", 32'(tuser), 32'h0);
    checkOutput("b0_tlast", 32'(tlast), 32'h0);
    checkOutput("b0_frame", 32'(frameCnt), 32'h1);
    stepTo(75);
    checkOutput("b1_tvalid", 32'(tvalid), 32'h1);
    checkOutput("b1_tdata", 32'(tdata), 32'h1234);
    checkOutput("b1_tuser", 32'(tuser), 32'h1);
    checkOutput("b1_tlast", 32'(tlast), 32'h1);
    stepTo(76);
    checkOutput("post_tvalid", 32'(tvalid), 32'h0);

    // Backpressure on the second packet for 20 cycles.
    $display("[TB] backpressure hold");
    stepTo(146);
    applyStimulus(1'b1, 1'b0);
    holdErr = 0;
    for (int c = 147; c <= 166; c++) begin
      stepTo(c);
      if (tvalid !== 1'b1 || tdata !== 16'hA5C3 || tuser !== 4'h0 || tlast !== 1'b0) holdErr++;
    end
    checkOutput("hold_err", 32'(holdErr), 32'd0);
    checkOutput("hold_frame", 32'(frameCnt), 32'h2);
    stepTo(167);
    checkOutput("rel_b0_tdata", 32'(tdata), 32'hA5C3);
    applyStimulus(1'b1, 1'b1);
    stepTo(168);
    checkOutput("rel_b1_tdata", 32'(tdata), 32'h1234);
    checkOutput("rel_b1_tlast", 32'(tlast), 32'h1);
    stepTo(169);
    checkOutput("rel_done", 32'(tvalid), 32'h0);
    checkOutput("rel_overrun", 32'(overrunCnt), 32'h0);

    // Overrun: frame 1 held, frame 2 dropped, frame 3 accepted.
    $display("[TB] overrun");
    applyStimulus(1'b1, 1'b0);
    resetDut();
    stepTo(80);
    adcWord = {16'hBEEF, 16'h0F0F};
    stepTo(100);
    checkOutput("ovr_held_tdata", 32'(tdata), 32'hA5C3);
    checkOutput("ovr_held_frame", 32'(frameCnt), 32'h1);
    stepTo(147);
    checkOutput("ovr_count", 32'(overrunCnt), 32'h1);
    checkOutput("ovr_frame", 32'(frameCnt), 32'h1);
    checkOutput("ovr_keep_tdata", 32'(tdata), 32'hA5C3);
    stepTo(160);
    checkOutput("ovr_b0_tuser", 32'(tuser), 32'h0);
    applyStimulus(1'b1, 1'b1);
    stepTo(161);
    checkOutput("ovr_b1_tdata", 32'(tdata), 32'h1234);
    checkOutput("ovr_b1_tlast", 32'(tlast), 32'h1);
    stepTo(162);
    checkOutput("ovr_done", 32'(tvalid), 32'h0);
    stepTo(218);
    checkOutput("ovr_frame_pre", 32'(frameCnt), 32'h1);
    stepTo(220);
    checkOutput("ovr_frame_post", 32'(frameCnt), 32'h2);
    checkOutput("ovr_new_tdata", 32'(tdata), 32'h0F0F);
    applyStimulus(1'b1, 1'b0);

    // Reset mid-SHIFT with a packet still buffered.
    $display("[TB] reset mid-frame");
    stepTo(240);
    resetn = 1'b0;
    stepTo(241);
    checkOutput("mrst_cs_n", 32'(cs_n), 32'h1);
    checkOutput("mrst_sclk", 32'(sclk), 32'h0);
    checkOutput("mrst_tvalid", 32'(tvalid), 32'h0);
    checkOutput("mrst_tlast", 32'(tlast), 32'h0);
    checkOutput("mrst_overrun", 32'(overrunCnt), 32'h0);
    checkOutput("mrst_frame", 32'(frameCnt), 32'h0);
    resetn  = 1'b1;
    adcWord = {16'h7FFE, 16'h8001};
    applyStimulus(1'b1, 1'b1);
    stepTo(314);
    checkOutput("restart_early", 32'(tvalid), 32'h0);
    stepTo(315);
    checkOutput("restart_tvalid", 32'(tvalid), 32'h1);
    checkOutput("restart_b0", 32'(tdata), 32'h8001);
    checkOutput("restart_frame", 32'(frameCnt), 32'h1);
    stepTo(316);
    checkOutput("restart_b1", 32'(tdata), 32'h7FFE);

    // LOAD coincides with the last-beat handshake: frame accepted, tvalid stays high.
    $display("[TB] load on last beat");
    stepTo(387);
    applyStimulus(1'b1, 1'b0);
    stepTo(390);
    adcWord = {16'hC3C3, 16'h3C3C};
    stepTo(459);
    checkOutput("coin_b0", 32'(tdata), 32'h8001);
    applyStimulus(1'b1, 1'b1);
    stepTo(460);
    checkOutput("coin_b1", 32'(tdata), 32'h7FFE);
    checkOutput("coin_tlast", 32'(tlast), 32'h1);
    stepTo(461);
    checkOutput("coin_tvalid", 32'(tvalid), 32'h1);
    checkOutput("coin_new_b0", 32'(tdata), 32'h3C3C);
    checkOutput("coin_tuser", 32'(tuser), 32'h0);
    checkOutput("coin_frame", 32'(frameCnt), 32'h3);
    checkOutput("coin_overrun", 32'(overrunCnt), 32'h0);

    // enable dropped mid-frame: the frame finishes and the FSM parks in IDLE.
    $display("[TB] enable drop");
    adcWord = {16'h1234, 16'hA5C3};
    resetDut();
    stepTo(20);
    applyStimulus(1'b0, 1'b1);
    stepTo(72);
    checkOutput("drop_cs_low", 32'(cs_n), 32'h0);
    stepTo(73);
    checkOutput("drop_cs_load", 32'(cs_n), 32'h1);
    stepTo(74);
    checkOutput("drop_b0", 32'(tdata), 32'hA5C3);
    stepTo(75);
    checkOutput("drop_b1", 32'(tdata), 32'h1234);
    quietErr = 0;
    for (int c = 76; c <= 200; c++) begin
      stepTo(c);
      if (cs_n !== 1'b1 || tvalid !== 1'b0 || sclk !== 1'b0) quietErr++;
    end
    checkOutput("drop_quiet", 32'(quietErr), 32'd0);
    checkOutput("drop_frame", 32'(frameCnt), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/axis_spi_adc_multich.md
Name: axis_spi_adc_multich

Overview:
Parametrised multi-channel successor to the single-channel MAX1119x AXIS reader. It drives a shared cs_n/SCLK pair to NUM_CH serial ADCs, each with its own miso line, and captures DATA_W-bit frames from all channels in parallel. Each captured frame is emitted as one AXI-Stream packet of NUM_CH beats, with a channel index on tuser. The whole block runs in the clk domain: SCLK is a registered output gated by a clock-enable, not a derived clock. Frames that arrive while the output buffer is still busy are dropped and counted.

Parameters:
- DATA_W, 16: bits per conversion frame and AXIS tdata width (4..32).
- NUM_CH, 2: number of parallel ADC channels (1..16).
- CLK_DIV, 10: clk cycles per SCLK half-period (>=1).
- CONV_CYC, 30: clk cycles cs_n is held high in CONV for conversion time (>=1).

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low.
- enable  in  1  run request; sampled only in IDLE and at the end of LOAD.
- miso  in  NUM_CH  serial data; bit i belongs to channel i.
- cs_n  out  1  shared chip select, active-low.
- sclk  out  1  shared serial clock, idles low.
- m_axis_tdata  out  DATA_W  sample, MSB-first assembled.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tready  in  1  AXIS ready.
- m_axis_tlast  out  1  high on the channel NUM_CH-1 beat.
- m_axis_tuser  out  4  channel index of the current beat.
- overrun_cnt  out  16  dropped-frame count; saturates at 0xFFFF.
- frame_cnt  out  16  accepted-frame count; wraps.

Behaviour:
- Reset values: cs_n=1, sclk=0, tvalid=0, tlast=0, tdata=0, tuser=0, overrun_cnt=0, frame_cnt=0, FSM=IDLE, output buffer empty.
- Capture FSM states: IDLE, CONV, SHIFT, LOAD.
- IDLE: cs_n=1. Moves to CONV on the next cycle when enable=1.
- CONV: cs_n=1 for exactly CONV_CYC cycles, then moves to SHIFT.
- SHIFT: cs_n=0 for exactly 2*CLK_DIV*DATA_W cycles.
  - sclk toggles every CLK_DIV cycles, starting low, giving DATA_W rising edges and ending low.
  - On each clk edge where sclk goes 0->1, every channel shift register takes {sr[DATA_W-2:0], miso[i]}.
  - The ADC drives miso on falling edges.
  - Then moves to LOAD.
- LOAD: 1 cycle, cs_n=1.
  - If the output buffer is empty, copy all NUM_CH shift registers into it and increment frame_cnt.
  - Otherwise drop the frame and increment overrun_cnt (saturating).
  - Next state: CONV if enable=1, else IDLE.
- Frame period while enabled: CONV_CYC + 2*CLK_DIV*DATA_W + 1 cycles.
- enable=0 during CONV or SHIFT: the current frame completes, including LOAD, and the FSM then goes to IDLE. cs_n never deasserts mid-frame.
- Output side runs independently of capture. When the buffer is loaded, tvalid rises on the next cycle with beat index 0.
  - Each beat: tdata = channel k, tuser = k, tlast = (k == NUM_CH-1).
  - A beat completes on tvalid & tready; the index then advances with no bubble.
  - While tvalid=1 and tready=0, tdata/tuser/tlast are held stable.
  - After the last beat, tvalid falls and the buffer is empty.
- Simultaneous events: a LOAD in the same cycle as the last-beat handshake sees the buffer as empty and accepts the frame. tvalid then stays high into beat 0 of the new packet the next cycle.
- Reset mid-operation (any state): the next edge forces reset values. The partial frame and the buffered packet are discarded, and no tlast is emitted.

Test Plan:
Common configuration for all tests: DATA_W=16, NUM_CH=2, CLK_DIV=2, CONV_CYC=8. Frame period is 73 cycles.
1. enable high at cycle 0, tready=1, ADC models shift 0xA5C3 (ch0) and 0x1234 (ch1) -> cs_n low cycles 9..72, LOAD at 73; tvalid at cycle 74 with beat 0x A5C3/tuser=0/tlast=0, cycle 75 with 0x1234/tuser=1/tlast=1; frame_cnt=1.
2. Timing check -> exactly 16 sclk rising edges per cs_n-low window, each high and low phase 2 cycles, sclk=0 whenever cs_n=1.
3. tready=0 for 20 cycles after tvalid rises -> tdata stays 0xA5C3 with tuser=0 throughout; after release, both beats delivered in order; no loss.
4. tready=0 from cycle 0 to cycle 160 with continuous enable -> frame 1 held; LOAD at cycle 146 dropped, overrun_cnt=1; after release the packet contains frame-1 data; frame_cnt=1 until the next LOAD.
5. resetn=0 for one cycle at cycle 40 (mid-SHIFT) -> cs_n=1, sclk=0, tvalid=0 immediately; with enable held high, restart gives the next LOAD at cycle 41+73.
6. enable dropped at cycle 20 -> the frame completes, LOAD occurs at 73, FSM goes to IDLE with cs_n=1; no further cs_n assertion; one packet is emitted.
